// File: rtl/conv_enc_stream.sv
// Streaming rate-1/N convolutional encoder with run-time K, N and generator taps.
// Optional zero-tail termination, one-deep registered output stage with backpressure.
module conv_enc_stream #(
  parameter int MAX_K = 9,
  parameter int MAX_N = 4
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic [3:0]                  i_constr_len,
  input  logic [2:0]                  i_code_rate,
  input  logic [MAX_N-1:0][MAX_K-1:0] i_gen_poly,
  input  logic                        i_term_mode,
  input  logic                        i_valid,
  input  logic                        i_bit,
  input  logic                        i_last,
  output logic                        o_ready,
  output logic                        o_valid,
  output logic [MAX_N-1:0]            o_data,
  output logic                        o_last,
  input  logic                        i_ready,
  output logic                        o_busy,
  output logic                        o_cfg_err
);

  localparam int CW = $clog2(MAX_K);

  typedef enum logic [1:0] {IDLE, ENC, FLUSH, DROP} state_e;

  state_e                      state_q, state_d;
  logic [3:0]                  k_q, k_d;
  logic [2:0]                  n_q, n_d;
  logic [MAX_N-1:0][MAX_K-1:0] poly_q, poly_d;
  logic                        term_q, term_d;
  logic [MAX_K-2:0]            sr_q, sr_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        vld_q, vld_d;
  logic [MAX_N-1:0]            data_q, data_d;
  logic                        last_q, last_d;
  logic                        err_q, err_d;

  logic [3:0]                  enc_k;
  logic [2:0]                  enc_n;
  logic [MAX_N-1:0][MAX_K-1:0] enc_poly;
  logic                        enc_bit;
  logic [MAX_K-1:0]            taps, kmask;
  logic [MAX_N-1:0]            enc_data;
  logic [MAX_K-2:0]            sr_shift;
  logic                        cfg_ok, out_free, accept, load, ld_last;

  // In IDLE the first bit is encoded with the live configuration, later bits with the latched copy.
  always_comb begin
    enc_k    = (state_q == IDLE) ? i_constr_len : k_q;
    enc_n    = (state_q == IDLE) ? i_code_rate  : n_q;
    enc_poly = (state_q == IDLE) ? i_gen_poly   : poly_q;
    enc_bit  = (state_q == FLUSH) ? 1'b0 : i_bit;
    taps     = {sr_q, enc_bit};
    sr_shift = {sr_q[MAX_K-3:0], enc_bit};
    for (int unsigned i = 0; i < MAX_K; i++) kmask[i] = (i < 32'(enc_k));
    for (int unsigned j = 0; j < MAX_N; j++)
      enc_data[j] = (j < 32'(enc_n)) & (^(enc_poly[j] & taps & kmask));
    cfg_ok = (i_constr_len >= 4'd3) && (32'(i_constr_len) <= MAX_K) &&
             (i_code_rate >= 3'd2) && (32'(i_code_rate) <= MAX_N);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      n_q     <= '0;
      poly_q  <= '0;
      term_q  <= 1'b0;
      sr_q    <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      poly_q  <= poly_d;
      term_q  <= term_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    poly_d  = poly_q;
    term_d  = term_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q && !i_ready;
    data_d  = data_q;
    last_d  = last_q;
    err_d   = 1'b0;
    load    = 1'b0;
    ld_last = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (!cfg_ok) begin
          err_d = 1'b1;
          if (!i_last) state_d = DROP;
        end else begin
          k_d    = i_constr_len;
          n_d    = i_code_rate;
          poly_d = i_gen_poly;
          term_d = i_term_mode;
          load   = 1'b1;
          sr_d   = sr_shift;
          if (!i_last) state_d = ENC;
          else if (i_term_mode) begin
            state_d = FLUSH;
            cnt_d   = CW'(i_constr_len - 4'd1);
          end else begin
            ld_last = 1'b1;
            sr_d    = '0;
          end
        end
      end
      ENC: if (accept) begin
        load = 1'b1;
        sr_d = sr_shift;
        if (i_last) begin
          if (term_q) begin
            state_d = FLUSH;
            cnt_d   = CW'(k_q - 4'd1);
          end else begin
            state_d = IDLE;
            ld_last = 1'b1;
            sr_d    = '0;
          end
        end
      end
      FLUSH: if (out_free) begin
        load  = 1'b1;
        sr_d  = sr_shift;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          ld_last = 1'b1;
          sr_d    = '0;
        end
      end
      DROP: if (accept && i_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (load) begin
      vld_d  = 1'b1;
      data_d = enc_data;
      last_d = ld_last;
    end
  end

  always_comb begin
    out_free  = !vld_q || i_ready;
    o_ready   = !rst && (state_q != FLUSH) && out_free;
    accept    = i_valid && o_ready;
    o_busy    = (state_q != IDLE);
    o_valid   = vld_q;
    o_data    = data_q;
    o_last    = last_q;
    o_cfg_err = err_q;
  end

endmodule

// File: tb/tb_conv_enc_stream.sv
// Self-checking bench for conv_enc_stream: directed frames plus randomized frames
// scored against a direct sum-of-taps convolution model.
module tb_conv_enc_stream;
  localparam int MK = 9;
  localparam int MN = 4;
  typedef logic [MN-1:0][MK-1:0] poly_t;

  logic          sys_clk, rst;
  logic [3:0]    i_constr_len;
  logic [2:0]    i_code_rate;
  poly_t         i_gen_poly;
  logic          i_term_mode, i_valid, i_bit, i_last, i_ready;
  logic          o_ready, o_valid, o_last, o_busy, o_cfg_err;
  logic [MN-1:0] o_data;

  conv_enc_stream #(.MAX_K(MK), .MAX_N(MN)) dut (
    .sys_clk(sys_clk), .rst(rst), .i_constr_len(i_constr_len), .i_code_rate(i_code_rate),
    .i_gen_poly(i_gen_poly), .i_term_mode(i_term_mode), .i_valid(i_valid), .i_bit(i_bit),
    .i_last(i_last), .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .o_last(o_last),
    .i_ready(i_ready), .o_busy(o_busy), .o_cfg_err(o_cfg_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int          n_cmp = 0, n_bad = 0;
  logic [MN:0] exp_q[$];
  int          exp_err = 0, seen_err = 0, cyc = 0, hs_cnt = 0, first_hs = -1, last_hs = -1;
  int          rdy_mode = 0, hold = 0;
  logic        prev_stall = 1'b0, prev_err = 1'b0;
  logic [MN:0] prev_sym = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic legal(input int k, input int n);
    return (k >= 3) && (k <= MK) && (n >= 2) && (n <= MN);
  endfunction

  function automatic poly_t rand_poly();
    poly_t p;
    for (int j = 0; j < MN; j++) p[j] = MK'($urandom);
    return p;
  endfunction

  // Output j at time t = XOR over i<k of p[j][i] * x[t-i], with x zero before the frame and in the tail.
  function automatic logic [MN-1:0] ref_sym(input logic [63:0] x, input int t, input int k,
                                            input int n, input poly_t p);
    logic [MN-1:0] s = '0;
    for (int j = 0; j < n; j++)
      for (int i = 0; i < k; i++)
        if (t - i >= 0 && p[j][i] && x[t-i]) s[j] = ~s[j];
    return s;
  endfunction

  task automatic push_model(input logic [63:0] bits, input int len, input int k, input int n,
                            input poly_t p, input logic term);
    logic [63:0] x = bits & ((64'd1 << len) - 64'd1);
    int total = len + (term ? k - 1 : 0);
    for (int t = 0; t < total; t++) exp_q.push_back({t == total - 1, ref_sym(x, t, k, n, p)});
  endtask

  task automatic send_frame(input logic [63:0] bits, input int len, input int k, input int n,
                            input poly_t p, input logic term, input int gap_pct,
                            input logic use_model, output int stalls);
    int   b = 0, guard = 0;
    logic ok = legal(k, n);
    logic acc;
    stalls = 0;
    if (!ok) exp_err++;
    else if (use_model) push_model(bits, len, k, n, p, term);
    while (b < len) begin
      @(negedge sys_clk);
      i_valid = ($urandom_range(99) >= gap_pct);
      i_bit   = bits[b];
      i_last  = (b == len - 1);
      if (b == 0) begin
        i_constr_len = 4'(k); i_code_rate = 3'(n); i_gen_poly = p; i_term_mode = term;
      end else begin
        i_constr_len = 4'($urandom); i_code_rate = 3'($urandom);
        i_gen_poly = rand_poly(); i_term_mode = 1'($urandom);
      end
      #2;
      acc = i_valid && o_ready;
      if (i_valid && !o_ready) stalls++;
      @(posedge sys_clk);
      #1;
      if (acc) begin
        i_valid = 1'b0;
        check("busy_after_bit", 32'(o_busy), i_last ? 32'(ok && term) : 32'd1);
        b++;
      end
      if (++guard > 2000) begin
        check("send_timeout", b, len);
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((exp_q.size() != 0 || o_busy || o_valid) && g < 500) begin
      @(negedge sys_clk);
      #3;
      g++;
    end
    check("drain_in_time", 32'(g < 500), 1);
    check("leftover_syms", exp_q.size(), 0);
  endtask

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  // Sink: drives i_ready, scores handshaken symbols, checks hold/backpressure and error pulses.
  initial forever begin
    @(negedge sys_clk);
    if (hold > 0) begin
      i_ready = 1'b0;
      hold--;
    end else if (rdy_mode == 1) i_ready = ($urandom_range(99) < 70);
    else i_ready = 1'b1;
    #2;
    if (!rst) begin
      if (o_cfg_err) begin
        seen_err++;
        check("err_pulse_len", 32'(prev_err), 0);
      end
      prev_err = o_cfg_err;
      if (prev_stall) check("hold_stable", {o_valid, o_last, o_data}, {1'b1, prev_sym});
      if (o_valid && !i_ready) check("ready_low_on_stall", 32'(o_ready), 0);
      prev_stall = o_valid && !i_ready;
      prev_sym   = {o_last, o_data};
      if (o_valid && i_ready) begin
        check("sym_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("symbol", {o_last, o_data}, exp_q.pop_front());
        hs_cnt++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
    end else begin
      prev_stall = 1'b0;
      prev_err   = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    poly_t p75, p;
    int    st, st2, h0, e0;
    int    bad_k[7] = '{0, 1, 2, 10, 13, 14, 15};
    int    bad_n[5] = '{0, 1, 5, 6, 7};
    int    k, n, len;

    rst = 1'b1; i_valid = 1'b0; i_bit = 1'b0; i_last = 1'b0; i_ready = 1'b1;
    i_constr_len = 4'd3; i_code_rate = 3'd2; i_gen_poly = '0; i_term_mode = 1'b0;
    p75 = '0; p75[0] = 9'd7; p75[1] = 9'd5;
    #2;
    check("reset_outs", {o_ready, o_valid, o_data, o_last, o_busy, o_cfg_err}, 0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(o_ready), 1);

    // K=3 7/5 zero-tail, input 1011
    exp_q.push_back(5'b0_0011); exp_q.push_back(5'b0_0001); exp_q.push_back(5'b0_0000);
    exp_q.push_back(5'b0_0010); exp_q.push_back(5'b0_0010); exp_q.push_back(5'b1_0011);
    send_frame(64'hD, 4, 3, 2, p75, 1'b1, 0, 1'b0, st);
    check("zt_stalls", st, 0);
    wait_idle();

    // same stimulus truncated, twice back to back
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(5'b0_0011); exp_q.push_back(5'b0_0001);
      exp_q.push_back(5'b0_0000); exp_q.push_back(5'b1_0010);
      send_frame(64'hD, 4, 3, 2, p75, 1'b0, 0, 1'b0, st);
      check("trunc_stalls", st, 0);
    end
    wait_idle();

    // backpressure: i_ready low 3 cycles mid-frame
    h0 = hs_cnt;
    p  = rand_poly();
    fork
      send_frame({$urandom, $urandom}, 10, 4, 3, p, 1'b1, 0, 1'b1, st);
      begin
        repeat (4) @(posedge sys_clk);
        hold = 3;
      end
    join
    wait_idle();
    check("bp_sym_count", hs_cnt - h0, 13);

    // illegal K=2 frame is dropped, then a legal frame
    e0 = seen_err;
    send_frame({$urandom, $urandom}, 3, 2, 2, p75, 1'b1, 0, 1'b1, st);
    repeat (3) @(posedge sys_clk);
    check("cfg_err_pulses", seen_err - e0, 1);
    send_frame({$urandom, $urandom}, 5, 3, 2, rand_poly(), 1'b1, 0, 1'b1, st);
    wait_idle();

    // reset during second flush cycle, K=5
    send_frame({$urandom, $urandom}, 6, 5, 3, rand_poly(), 1'b1, 0, 1'b1, st);
    @(negedge sys_clk);
    @(negedge sys_clk);
    #1 rst = 1'b1;
    #1;
    check("rst_flush_outs", {o_ready, o_valid, o_data, o_last, o_busy, o_cfg_err}, 0);
    check("flush_syms_left", exp_q.size(), 4);
    exp_q.delete();
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b0;
    #1;
    check("ready_after_rst2", 32'(o_ready), 1);
    send_frame({$urandom, $urandom}, 7, 5, 3, rand_poly(), 1'b1, 0, 1'b1, st);
    wait_idle();

    // K=9 N=4 back-to-back zero-tail frames at full rate
    h0 = hs_cnt;
    first_hs = -1;
    send_frame({$urandom, $urandom}, 10, 9, 4, rand_poly(), 1'b1, 0, 1'b1, st);
    send_frame({$urandom, $urandom}, 10, 9, 4, rand_poly(), 1'b1, 0, 1'b1, st2);
    wait_idle();
    check("k9_f1_stalls", st, 0);
    check("k9_f2_stalls", st2, 8);
    check("k9_sym_count", hs_cnt - h0, 36);
    check("k9_span", last_hs - first_hs, 35);

    // randomized frames with random gaps, backpressure and occasional illegal configs
    rdy_mode = 1;
    for (int f = 0; f < 40; f++) begin
      k   = $urandom_range(MK, 3);
      n   = $urandom_range(MN, 2);
      len = $urandom_range(16, 1);
      if ($urandom_range(99) < 10) k = bad_k[$urandom_range(6)];
      else if ($urandom_range(99) < 8) n = bad_n[$urandom_range(4)];
      send_frame({$urandom, $urandom}, len, k, n, rand_poly(), 1'($urandom), 25, 1'b1, st);
      if ($urandom_range(3) == 0) wait_idle();
    end
    wait_idle();
    repeat (3) @(posedge sys_clk);
    check("cfg_err_total", seen_err, exp_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
